// File: rtl/md_unit.sv
// Multiply/divide unit beside the E-stage ALU: computes the result at accept time,
// then holds it for a fixed latency before committing it to HI/LO.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] ph_p1;
    logic [31:0] pl_p1;
    logic        wr_p1;
    logic [63:0] res_p0;

    function automatic logic [63:0] mul_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        logic signed [63:0] p;
        ax = 64'(a);
        bx = 64'(b);
        p  = ax * bx;
        return p;
    endfunction

    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Widening to 64 bits makes 0x80000000 / -1 exact: quotient 2^31 truncates to 0x80000000.
    function automatic logic [63:0] div_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        logic signed [63:0] q;
        logic signed [63:0] r;
        ax = 64'(a);
        bx = 64'(b);
        if (b == 32'sd0) begin
            q = 64'sd0;
            r = 64'sd0;
        end else begin
            q = ax / bx;
            r = ax % bx;
        end
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    always_comb begin
        res_p0 = 64'd0;
        case (MDOp)
            3'd0:    res_p0 = mul_s(A, B);
            3'd1:    res_p0 = mul_u(A, B);
            3'd2:    res_p0 = div_s(A, B);
            3'd3:    res_p0 = div_u(A, B);
            default: res_p0 = 64'd0;
        endcase
    end

    // p0 -> p1: result is captured on accept and held in ph/pl until the counter expires
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= 4'd0;
            ph_p1 <= 32'd0;
            pl_p1 <= 32'd0;
            wr_p1 <= 1'b0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            3'd0, 3'd1: begin
                                ph_p1 <= res_p0[63:32];
                                pl_p1 <= res_p0[31:0];
                                wr_p1 <= 1'b1;
                                cnt   <= MULT_LOAD;
                                Busy  <= 1'b1;
                                state <= RUN;
                            end
                            3'd2, 3'd3: begin
                                ph_p1 <= res_p0[63:32];
                                pl_p1 <= res_p0[31:0];
                                wr_p1 <= (B != 32'd0);
                                cnt   <= DIV_LOAD;
                                Busy  <= 1'b1;
                                state <= RUN;
                            end
                            3'd4:    HI <= A;
                            3'd5:    LO <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // A divide by zero runs the full latency but leaves HI/LO untouched
                        if (wr_p1) begin
                            HI <= ph_p1;
                            LO <= pl_p1;
                        end
                        wr_p1 <= 1'b0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a cycle-indexed behavioural model checked every cycle, plus
// literal expectations for the documented cases.
module tb_md_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .Clk(clk), .Reset(rst), .Start(start), .MDOp(mdop),
        .A(a), .B(b), .Busy(busy), .HI(hi), .LO(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an accepted op at edge k is due at edge k+N; busy means "an op is still due".
    int          m_cyc;
    int          m_done;
    logic        m_fly;
    logic        m_wr;
    logic [63:0] m_res;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    function automatic logic [63:0] model_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy;
        longint unsigned ux, uy;
        logic [63:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        r  = 64'd0;
        case (op)
            3'd0: r = 64'(sx * sy);
            3'd1: r = ux * uy;
            3'd2: if (y != 0) r = {32'(sx % sy), 32'(sx / sy)};
            3'd3: if (y != 0) r = {32'(ux % uy), 32'(ux / uy)};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 0; m_done <= 0; m_fly <= 1'b0; m_wr <= 1'b0;
            m_res <= 64'd0; m_hi <= 32'd0; m_lo <= 32'd0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_fly) begin
                if (m_cyc + 1 == m_done) begin
                    if (m_wr) begin
                        m_hi <= m_res[63:32];
                        m_lo <= m_res[31:0];
                    end
                    m_fly <= 1'b0;
                end
            end else if (start) begin
                if (mdop <= 3'd3) begin
                    m_res  <= model_res(mdop, a, b);
                    m_wr   <= (mdop <= 3'd1) || (b != 32'd0);
                    m_fly  <= 1'b1;
                    m_done <= m_cyc + 1 + ((mdop <= 3'd1) ? MULT_CYCLES : DIV_CYCLES);
                end else if (mdop == 3'd4) begin
                    m_hi <= a;
                end else if (mdop == 3'd5) begin
                    m_lo <= a;
                end
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (busy !== m_fly || hi !== m_hi || lo !== m_lo) begin
            miscompares++;
            $display("FAIL model t=%0t busy=%b hi=%h lo=%h, required busy=%b hi=%h lo=%h",
                     $time, busy, hi, lo, m_fly, m_hi, m_lo);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        tick();
        start = 1'b1; mdop = op; a = x; b = y;
        tick();
        start = 1'b0; a = 32'd0; b = 32'd0;
    endtask

    // Counts negedges with Busy high until it drops; an expired bound is a failure.
    task automatic busy_len(input string name, input int exp);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (busy) n++;
            else done = 1'b1;
        end
        if (!done) $display("FAIL %s_timeout busy still high after 40 cycles", name);
        check(name, 32'(n), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; mdop = 3'd0; a = 32'd0; b = 32'd0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;

        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        busy_len("mult_busy", 5);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFFA);

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        busy_len("multu_busy", 5);
        check("multu_hi", hi, 32'hFFFFFFFE);
        check("multu_lo", lo, 32'h00000001);

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        busy_len("div_busy", 10);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        issue(3'd3, 32'd7, 32'd2);
        busy_len("divu_busy", 10);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        issue(3'd4, 32'h1234, 32'd0);
        check("mthi_hi", hi, 32'h1234);
        check("mthi_lo", lo, 32'd3);
        issue(3'd2, 32'd5, 32'd0);
        busy_len("div0_busy", 10);
        check("div0_hi", hi, 32'h1234);
        check("div0_lo", lo, 32'd3);

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        busy_len("divovf_busy", 10);
        check("divovf_lo", lo, 32'h80000000);
        check("divovf_hi", hi, 32'd0);

        issue(3'd6, 32'hAAAA5555, 32'd1);
        @(negedge clk);
        check("rsvd_busy", 32'(busy), 32'd0);
        check("rsvd_lo", lo, 32'h80000000);

        // Reset dropped in the middle of a divide, away from any clock edge.
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (15) @(negedge clk);
        check("arst_nowrite_lo", lo, 32'd0);
        check("arst_nowrite_busy", 32'(busy), 32'd0);

        // Stray mtlo while a mult is in flight must be ignored.
        issue(3'd0, 32'hFFFFFFFD, 32'h40000000);
        repeat (2) @(negedge clk);
        issue(3'd5, 32'h0000DEAD, 32'd0);
        $display("note: start issued during busy at t=%0t", $time);
        busy_len("b2b_busy", 2);
        check("b2b_hi", hi, 32'hFFFFFFFF);
        check("b2b_lo", lo, 32'h40000000);
        issue(3'd5, 32'd9, 32'd0);
        @(negedge clk);
        check("mtlo_lo", lo, 32'd9);
        check("mtlo_hi", hi, 32'hFFFFFFFF);

        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
